alu_arbiter: RTL
================

# alu_arbiter

Shares one combinational `alu` instance between two requesters (main datapath issue and address/branch-compare unit) using valid/ready handshakes and round-robin arbitration. Operands are registered into a single output stage, giving a 1-cycle result latency at full throughput. Unsupported `alu_ctl` codes are flagged rather than silently executed.

## Interface
- `XLEN`, 64, operand/result width.
- `clk` in 1, rising-edge clock.
- `rst_n` in 1, asynchronous active-low reset.
- `req0_valid` in 1, requester 0 has an operation.
- `req0_ready` out 1, requester 0 operation accepted this cycle.
- `req0_rs1` in XLEN, operand A.
- `req0_rs2` in XLEN, operand B.
- `req0_ctl` in 4, ALU op code.
- `req1_valid`, `req1_ready`, `req1_rs1`, `req1_rs2`, `req1_ctl`: same as requester 0, for requester 1.
- `resp_valid` out 1, output stage holds a result.
- `resp_ready` in 1, consumer takes the result.
- `resp_id` out 1, requester that issued the result.
- `resp_data` out XLEN, ALU result.
- `resp_zero` out 1, `resp_data == 0`.
- `resp_err` out 1, op code was unsupported.

## Operation
- Supported codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 1001. All other codes are illegal.
- Shift amount is `rs2[5:0]`. SRA is arithmetic on `rs1`. ADD and SUB wrap modulo 2^XLEN.
- `can_accept = !resp_valid || resp_ready`.
- Grant:
  - Only one requester valid: grant it.
  - Both valid: grant the one `rr_ptr` selects.
  - Neither valid: no grant.
- `reqN_ready = can_accept && grant_N`. The non-granted requester sees ready = 0.
- Ready depends combinationally on valid. Requesters must not derive valid from ready, and must hold the payload stable while `valid && !ready`.
- On handshake of requester N:
  - Load `resp_data` and `resp_zero` from the ALU.
  - Load `resp_id = N` and `resp_err = 0`.
  - Set `resp_valid = 1`.
  - Set `rr_ptr = !N`. `rr_ptr` updates only on a handshake, never on an idle cycle.
- Illegal code: the handshake still completes. Load `resp_data = 0`, `resp_zero = 1`, `resp_err = 1`.
- Consumer drain (`resp_valid && resp_ready`) with no new handshake: clear `resp_valid`. Data fields keep their last values.
- Output stage states:
  - EMPTY → FULL on handshake.
  - FULL → EMPTY on drain with no handshake.
  - FULL → FULL on simultaneous drain and handshake.
  - FULL holds while stalled.

## Timing
- Reset values: `resp_valid` 0, `resp_id` 0, `resp_data` 0, `resp_zero` 0, `resp_err` 0, `rr_ptr` 0 (requester 0 first).
- Latency: handshake in cycle T gives `resp_valid` = 1 with its result from cycle T+1.
- Throughput: one operation per cycle while `resp_ready` is held high.
- Backpressure: while `resp_valid && !resp_ready`, all `resp_*` outputs are stable and both `reqN_ready` are 0.
- Reset asserted mid-operation discards any pending result immediately (asynchronous). The first grant after release goes to requester 0 if both are valid.
- `req*_ready` is 0 whenever `rst_n` is 0.

## Structure
- Shared package `alu_pkg`:
  - `XLEN` default.
  - Op-code constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_XOR`, `ALU_SLL`, `ALU_SRL`, `ALU_SUB`, `ALU_SRA`.
  - Function `alu_ctl_legal(ctl)`.
- One sub-module: the existing `alu` (ports `rs1_data`, `rs2_data`, `alu_ctl`, `alu_out`, `zero`), instantiated once and fed from the grant mux.
- Arbitration and the output register live inline in this block.

## Test plan
- **Single ADD:** req0 rs1=10, rs2=20, ctl=0010, `resp_ready`=1 → next cycle `resp_valid`=1, `resp_data`=30, `resp_id`=0, `resp_zero`=0, `resp_err`=0.
- **Round-robin:** both requesters valid for 4 cycles (req0 SUB 20-10, req1 XOR 12^10) → grants go 0,1,0,1. Results alternate 10 (id 0) and 6 (id 1). No bubbles.
- **Backpressure:** `resp_ready`=0 for 3 cycles after req1 SRA rs1=-8, rs2=1 → `resp_data`=0xFFFF_FFFF_FFFF_FFFC held stable, both readies 0. Release → drained, next op accepted in the same cycle.
- **Illegal code:** req0 ctl=1111 → `resp_err`=1, `resp_data`=0, `resp_zero`=1. `rr_ptr` toggles to requester 1.
- **Zero flag:** req1 SUB 5-5 → `resp_data`=0, `resp_zero`=1, `resp_err`=0.
- **Reset:** assert `rst_n`=0 while `resp_valid`=1 → all outputs 0 immediately. After release, both requesters valid → first grant to req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default width, op-code map and legality check.
package alu_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b1001;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic logic alu_ctl_legal(input logic [3:0] ctl);
        case (ctl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_XOR,
            ALU_SLL, ALU_SRL, ALU_SUB, ALU_SRA: alu_ctl_legal = 1'b1;
            default:                            alu_ctl_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; unsupported codes produce 0.
module alu #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [3:0]      alu_ctl,
    output logic [XLEN-1:0] alu_out,
    output logic            zero
);
    import alu_pkg::*;

    logic [5:0] shamt;
    assign shamt = rs2_data[5:0];

    always_comb begin
        alu_out = '0;
        case (alu_ctl)
            ALU_AND: alu_out = rs1_data & rs2_data;
            ALU_OR:  alu_out = rs1_data | rs2_data;
            ALU_ADD: alu_out = rs1_data + rs2_data;
            ALU_XOR: alu_out = rs1_data ^ rs2_data;
            ALU_SLL: alu_out = rs1_data << shamt;
            ALU_SRL: alu_out = rs1_data >> shamt;
            ALU_SUB: alu_out = rs1_data - rs2_data;
            ALU_SRA: alu_out = $unsigned($signed(rs1_data) >>> shamt);
            default: alu_out = '0;
        endcase
    end

    assign zero = (alu_out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters,
// with a single registered output stage.
module alu_arbiter #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic [3:0]      req0_ctl,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic [3:0]      req1_ctl,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_zero,
    output logic            resp_err
);
    import alu_pkg::*;

    out_state_e      state_q, state_d;
    logic            rr_ptr_q;
    logic            id_q;
    logic [XLEN-1:0] data_q;
    logic            zero_q;
    logic            err_q;

    logic            can_accept;
    logic            grant0, grant1;
    logic            hs, drain;
    logic            sel;
    logic [XLEN-1:0] mux_rs1, mux_rs2;
    logic [3:0]      mux_ctl;
    logic [XLEN-1:0] alu_out;
    logic            alu_zero;
    logic            legal;

    assign can_accept = (state_q == OUT_EMPTY) || resp_ready;

    // rr_ptr only breaks ties; a lone requester always wins.
    assign grant0 = req0_valid && (!req1_valid || !rr_ptr_q);
    assign grant1 = req1_valid && (!req0_valid ||  rr_ptr_q);

    assign hs    = can_accept && (grant0 || grant1);
    assign drain = (state_q == OUT_FULL) && resp_ready;
    assign sel   = grant1;

    assign req0_ready = rst_n && can_accept && grant0;
    assign req1_ready = rst_n && can_accept && grant1;

    assign mux_rs1 = sel ? req1_rs1 : req0_rs1;
    assign mux_rs2 = sel ? req1_rs2 : req0_rs2;
    assign mux_ctl = sel ? req1_ctl : req0_ctl;
    assign legal   = alu_ctl_legal(mux_ctl);

    alu #(.XLEN(XLEN)) u_alu (
        .rs1_data (mux_rs1),
        .rs2_data (mux_rs2),
        .alu_ctl  (mux_ctl),
        .alu_out  (alu_out),
        .zero     (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= OUT_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (hs) state_d = OUT_FULL;
            OUT_FULL:  if (drain && !hs) state_d = OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
    end

    always_comb begin
        resp_valid = (state_q == OUT_FULL);
        resp_id    = id_q;
        resp_data  = data_q;
        resp_zero  = zero_q;
        resp_err   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
            id_q     <= 1'b0;
            data_q   <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (hs) begin
            rr_ptr_q <= !sel;
            id_q     <= sel;
            data_q   <= legal ? alu_out : '0;
            zero_q   <= legal ? alu_zero : 1'b1;
            err_q    <= !legal;
        end
    end

endmodule
